// File: rtl/prefix_pkg.sv
// Shared definitions for the prefix (Kogge-Stone) add/sub datapath:
// default width, operation encoding and the result flag bundle.
package prefix_pkg;

   localparam int PREFIX_WIDTH = 16;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_t;

   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
      logic neg;
   } flags_t;

   // Number of prefix levels for a power-of-two width.
   function automatic int prefix_levels(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/prefix_pg_cell.sv
// Kogge-Stone black cell: merges a high group (g_hi,p_hi) with the
// adjacent lower group (g_lo,p_lo) into one wider group.
module prefix_pg_cell (
   input  logic g_hi_i,
   input  logic p_hi_i,
   input  logic g_lo_i,
   input  logic p_lo_i,
   output logic g_o,
   output logic p_o
);

   assign g_o = g_hi_i | (p_hi_i & g_lo_i);
   assign p_o = p_hi_i & p_lo_i;

endmodule

// File: rtl/prefix_addsub_pipe.sv
// Two-stage Kogge-Stone adder/subtractor with valid/ready on both sides.
// The first half of the prefix tree sits in S1, the rest plus flags in S2.
module prefix_addsub_pipe
   import prefix_pkg::*;
#(
   parameter int WIDTH = PREFIX_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] o,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int LEVELS = prefix_levels(WIDTH);
   localparam int L1     = (LEVELS + 1) / 2;

   function automatic flags_t calc_flags(input logic             carry,
                                         input logic             a_msb,
                                         input logic             b_msb,
                                         input logic [WIDTH-1:0] sum);
      flags_t f;
      f.cout = carry;
      f.ovf  = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
      f.zero = (sum == '0);
      f.neg  = sum[WIDTH-1];
      return f;
   endfunction

   // ---------------- control ----------------
   logic v1_q, v1_d;
   logic v2_q, v2_d;
   logic adv1, adv2;

   assign adv2     = !v2_q || out_ready;
   assign adv1     = !v1_q || adv2;
   assign in_ready = adv1;

   always_comb begin
      v1_d = v1_q;
      v2_d = v2_q;
      if (adv1) v1_d = in_valid;
      if (adv2) v2_d = v1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
      end
   end

   // ---------------- S0: operand conditioning ----------------
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] p0;
   logic [WIDTH-1:0] g0;

   assign b_eff = (op_t'(sel) == OP_SUB) ? ~b : b;
   assign p0    = a ^ b_eff;

   // Carry-in folded into bit 0 so every group generate already includes it.
   always_comb begin
      g0    = a & b_eff;
      g0[0] = g0[0] | (p0[0] & cin);
   end

   // ---------------- S1 registers ----------------
   logic [WIDTH-1:0] gg_p1_q;
   logic [WIDTH-1:0] gp_p1_q;
   logic [WIDTH-1:0] p_p1_q;
   logic             cin_p1_q;
   logic             amsb_p1_q;
   logic             bmsb_p1_q;
   logic [WIDTH-1:0] gg_p1_d;
   logic [WIDTH-1:0] gp_p1_d;

   // ---------------- prefix tree ----------------
   for (genvar lv = 0; lv < LEVELS; lv++) begin : g_lvl
      localparam int D = 1 << lv;
      logic [WIDTH-1:0] g_in;
      logic [WIDTH-1:0] p_in;
      logic [WIDTH-1:0] g_out;
      logic [WIDTH-1:0] p_out;

      if (lv == 0) begin : g_src_in
         assign g_in = g0;
         assign p_in = p0;
      end else if (lv == L1) begin : g_src_reg
         assign g_in = gg_p1_q;
         assign p_in = gp_p1_q;
      end else begin : g_src_prev
         assign g_in = g_lvl[lv-1].g_out;
         assign p_in = g_lvl[lv-1].p_out;
      end

      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i >= D) begin : g_cell
            prefix_pg_cell u_cell (
               .g_hi_i (g_in[i]),
               .p_hi_i (p_in[i]),
               .g_lo_i (g_in[i-D]),
               .p_lo_i (p_in[i-D]),
               .g_o    (g_out[i]),
               .p_o    (p_out[i])
            );
         end else begin : g_pass
            assign g_out[i] = g_in[i];
            assign p_out[i] = p_in[i];
         end
      end
   end

   assign gg_p1_d = g_lvl[L1-1].g_out;
   assign gp_p1_d = g_lvl[L1-1].p_out;

   // Datapath registers only capture; validity is tracked by v1_q.
   always_ff @(posedge clk) begin
      if (adv1) begin
         gg_p1_q   <= gg_p1_d;
         gp_p1_q   <= gp_p1_d;
         p_p1_q    <= p0;
         cin_p1_q  <= cin;
         amsb_p1_q <= a[WIDTH-1];
         bmsb_p1_q <= b_eff[WIDTH-1];
      end
   end

   // ---------------- S2: sum, flags, output register ----------------
   logic [WIDTH-1:0] g_fin;
   logic [WIDTH-1:0] sum_p2;
   flags_t           flags_p2;
   logic [WIDTH-1:0] o_q, o_d;
   flags_t           flags_q, flags_d;
   logic             unused_p;

   assign g_fin    = g_lvl[LEVELS-1].g_out;
   assign sum_p2   = p_p1_q ^ {g_fin[WIDTH-2:0], cin_p1_q};
   assign flags_p2 = calc_flags(g_fin[WIDTH-1], amsb_p1_q, bmsb_p1_q, sum_p2);
   assign unused_p = &{1'b0, g_lvl[LEVELS-1].p_out};

   always_comb begin
      o_d     = o_q;
      flags_d = flags_q;
      if (adv2 && v1_q) begin
         o_d     = sum_p2;
         flags_d = flags_p2;
      end
   end

   // Output register is reset so a discarded stream leaves all-zero outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_q     <= '0;
         flags_q <= '0;
      end else begin
         o_q     <= o_d;
         flags_q <= flags_d;
      end
   end

   assign out_valid = v2_q;
   assign o         = o_q;
   assign cout      = flags_q.cout;
   assign ovf       = flags_q.ovf;
   assign zero      = flags_q.zero;
   assign neg       = flags_q.neg;

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// Self-checking bench for prefix_addsub_pipe: directed cases plus a
// randomized stream scored against an arithmetic reference queue.
module tb_prefix_addsub_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        sel = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] o;
   logic        cout, ovf, zero, neg;

   prefix_addsub_pipe #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .o         (o),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero),
      .neg       (neg)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] o;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic        neg;
   } res_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   res_t exp_q[$];
   logic hold_valid = 1'b0;
   res_t hold_val;

   function automatic res_t model(input logic [15:0] aa, input logic [15:0] bb,
                                  input logic c, input logic s);
      res_t        r;
      logic [15:0] be;
      logic [16:0] full;
      be     = s ? ~bb : bb;
      full   = {1'b0, aa} + {1'b0, be} + {16'd0, c};
      r.o    = full[15:0];
      r.cout = full[16];
      r.ovf  = (aa[15] == be[15]) && (r.o[15] != aa[15]);
      r.zero = (r.o == 16'd0);
      r.neg  = r.o[15];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic res_t cur_out();
      return {o, cout, ovf, zero, neg};
   endfunction

   // Scoreboard: samples 1ns before each rising edge.
   always @(negedge clk) begin
      res_t e;
      #4;
      if (!rst_n) begin
         exp_q.delete();
         hold_valid = 1'b0;
      end else begin
         if (hold_valid) begin
            check("stall_valid_hold", {31'd0, out_valid}, 32'd1);
            check("stall_data_hold", {12'd0, cur_out()}, {12'd0, hold_val});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_output", {12'd0, cur_out()}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("result", {12'd0, cur_out()}, {12'd0, e});
            end
         end
         hold_valid = out_valid && !out_ready;
         hold_val   = cur_out();
         if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sel));
      end
   end

   // Drives one cycle's inputs after the falling edge; returns 1ns before the rising edge.
   task automatic cyc(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                      input logic c, input logic s, input logic ordy);
      @(negedge clk);
      #1;
      in_valid  = v;
      a         = aa;
      b         = bb;
      cin       = c;
      sel       = s;
      out_ready = ordy;
      #3;
   endtask

   task automatic expect_out(input string name, input logic [15:0] eo, input logic [3:0] ef);
      check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({name, "_o"}, {16'd0, o}, {16'd0, eo});
      check({name, "_flags"}, {28'd0, cout, ovf, zero, neg}, {28'd0, ef});
   endtask

   function automatic logic [15:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h8000;
         3:       return 16'h7FFF;
         default: return 16'($urandom());
      endcase
   endfunction

   initial begin
      logic        rv, rc, rs, ordy, hold_req;
      logic [15:0] ra, rb;

      // Model pinned against hand-computed values.
      check("model_add", {12'd0, model(16'hAAAA, 16'h5555, 1'b0, 1'b0)}, {12'd0, 16'hFFFF, 4'b0001});
      check("model_sub", {12'd0, model(16'hAAAA, 16'h5555, 1'b1, 1'b1)}, {12'd0, 16'h5555, 4'b1100});
      check("model_zero", {12'd0, model(16'hFFFF, 16'h0001, 1'b0, 1'b0)}, {12'd0, 16'h0000, 4'b1010});

      // Reset state.
      #2;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_outputs", {12'd0, cur_out()}, 32'd0);
      @(negedge clk);
      #6;
      rst_n = 1'b1;

      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

      // Single add, latency.
      cyc(1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b1);
      check("add_in_ready", {31'd0, in_ready}, 32'd1);
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      check("add_lat_not_yet", {31'd0, out_valid}, 32'd0);
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      expect_out("add", 16'hFFFF, 4'b0001);

      // Back-to-back adds.
      cyc(1'b1, 16'h002E, 16'h004F, 1'b0, 1'b0, 1'b1);
      check("b2b_rdy0", {31'd0, in_ready}, 32'd1);
      cyc(1'b1, 16'h0002, 16'h0004, 1'b0, 1'b0, 1'b1);
      check("b2b_rdy1", {31'd0, in_ready}, 32'd1);
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      expect_out("b2b0", 16'h007D, 4'b0000);
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      expect_out("b2b1", 16'h0006, 4'b0000);

      // Subtracts and zero/carry.
      cyc(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b1, 1'b1);
      cyc(1'b1, 16'h002E, 16'h004F, 1'b1, 1'b1, 1'b1);
      cyc(1'b1, 16'h0002, 16'h0004, 1'b1, 1'b1, 1'b1);
      expect_out("sub0", 16'h5555, 4'b1100);
      cyc(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      expect_out("sub1", 16'hFFDF, 4'b0001);
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      expect_out("sub2", 16'hFFFE, 4'b0001);
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      expect_out("zero_carry", 16'h0000, 4'b1010);

      // Stall with three requests.
      cyc(1'b1, 16'h1000, 16'h0001, 1'b0, 1'b0, 1'b0);
      check("stall_rdy0", {31'd0, in_ready}, 32'd1);
      cyc(1'b1, 16'h2000, 16'h0002, 1'b0, 1'b0, 1'b0);
      check("stall_rdy1", {31'd0, in_ready}, 32'd1);
      cyc(1'b1, 16'h3000, 16'h0003, 1'b0, 1'b0, 1'b0);
      check("stall_rdy2", {31'd0, in_ready}, 32'd0);
      expect_out("stall_first", 16'h1001, 4'b0000);
      cyc(1'b1, 16'h3000, 16'h0003, 1'b0, 1'b0, 1'b0);
      check("stall_rdy3", {31'd0, in_ready}, 32'd0);
      expect_out("stall_hold", 16'h1001, 4'b0000);
      cyc(1'b1, 16'h3000, 16'h0003, 1'b0, 1'b0, 1'b1);
      check("release_rdy", {31'd0, in_ready}, 32'd1);
      expect_out("release0", 16'h1001, 4'b0000);
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      expect_out("release1", 16'h2002, 4'b0000);
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      expect_out("release2", 16'h3003, 4'b0000);
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      check("release_drained", {31'd0, out_valid}, 32'd0);

      // Reset with both stages full.
      cyc(1'b1, 16'h0100, 16'h0001, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'h0200, 16'h0002, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'h0300, 16'h0003, 1'b0, 1'b0, 1'b0);
      check("full_before_reset", {30'd0, out_valid, in_ready}, 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
      check("midreset_outputs", {12'd0, cur_out()}, 32'd0);
      @(negedge clk);
      #6;
      rst_n = 1'b1;
      cyc(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
      check("after_reset_rdy", {30'd0, out_valid, in_ready}, 32'd1);
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      check("no_stale", {31'd0, out_valid}, 32'd0);
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      expect_out("after_reset", 16'h2345, 4'b0000);
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      check("after_reset_single", {31'd0, out_valid}, 32'd0);

      // Random stream; producer holds its request while not ready.
      hold_req = 1'b0;
      rv = 1'b0; ra = '0; rb = '0; rc = 1'b0; rs = 1'b0;
      for (int k = 0; k < 1500; k++) begin
         if (!hold_req) begin
            rv = ($urandom_range(0, 9) < 7);
            ra = pick_operand();
            rb = pick_operand();
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
         end
         ordy = ($urandom_range(0, 9) < 7);
         cyc(rv, ra, rb, rc, rs, ordy);
         hold_req = rv && !in_ready;
      end
      for (int k = 0; k < 4; k++) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      check("drain_queue_empty", exp_q.size(), 32'd0);
      check("drain_out_valid", {31'd0, out_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
